// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : WIDTH-bit unsigned adder {carry, sum} = a + b + c, built as a
//            ripple chain of 1-bit full-adder cells. Outputs are either
//            registered (REG_OUT=1, latency 1) or combinational (REG_OUT=0).
// Ports    : a, b      - addends, WIDTH bits, unsigned
//            c         - carry-in
//            sum       - low WIDTH bits of a+b+c
//            carry     - carry-out (bit WIDTH of a+b+c)
//            clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            in_valid  - qualifies a/b/c this cycle
//            out_valid - qualifies sum/carry
// Revision : 1.0 - initial release
// ============================================================================
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             out_valid
);

    // w_cy[i] is the carry into cell i; w_cy[WIDTH] is the final carry-out.
    logic [WIDTH:0]   w_cy;
    logic [WIDTH-1:0] w_sum;

    assign w_cy[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic w_p;
        assign w_p        = a[i] ^ b[i];
        assign w_sum[i]   = w_p ^ w_cy[i];
        assign w_cy[i+1]  = (a[i] & b[i]) | (w_cy[i] & w_p);
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] r_sum;
        logic             r_carry;
        logic             r_valid;

        // The data registers load only on in_valid, so idle cycles (and any
        // unknown values on a/b/c during them) never disturb the held result.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                r_valid <= in_valid;
                if (in_valid) begin
                    r_sum   <= w_sum;
                    r_carry <= w_cy[WIDTH];
                end
            end
        end

        assign sum       = r_sum;
        assign carry     = r_carry;
        assign out_valid = r_valid;
    end else begin : g_comb
        // Data path is purely combinational; reset only masks the qualifier.
        assign sum       = w_sum;
        assign carry     = w_cy[WIDTH];
        assign out_valid = in_valid & ~rst;
    end

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_adder
// Purpose  : Self-checking bench for full_adder. Four instances share one
//            stimulus bus: WIDTH=1/8/16 registered and WIDTH=1 combinational.
//            Expected registered results are queued when stimulus is driven
//            and compared one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_adder;

    logic        clk;
    logic        rst;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        c_i;
    logic        v_i;

    logic [15:0] s16;
    logic        c16, v16;
    logic [7:0]  s8;
    logic        c8, v8;
    logic [0:0]  s1;
    logic        c1, v1;
    logic [0:0]  sc;
    logic        cc, vc;

    full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_dut16 (
        .a(a_i), .b(b_i), .c(c_i), .sum(s16), .carry(c16),
        .clk(clk), .rst(rst), .in_valid(v_i), .out_valid(v16));

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
        .a(a_i[7:0]), .b(b_i[7:0]), .c(c_i), .sum(s8), .carry(c8),
        .clk(clk), .rst(rst), .in_valid(v_i), .out_valid(v8));

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
        .a(a_i[0:0]), .b(b_i[0:0]), .c(c_i), .sum(s1), .carry(c1),
        .clk(clk), .rst(rst), .in_valid(v_i), .out_valid(v1));

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_dutc (
        .a(a_i[0:0]), .b(b_i[0:0]), .c(c_i), .sum(sc), .carry(cc),
        .clk(clk), .rst(rst), .in_valid(v_i), .out_valid(vc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        v;
        logic        r;
        logic [7:0]  s8;
        logic        c8;
        logic        s1;
        logic        c1;
    } vec_t;

    typedef struct {
        logic        v;
        logic [15:0] s16;
        logic        c16;
        logic [7:0]  s8;
        logic        c8;
        logic        s1;
        logic        c1;
    } exp_t;

    exp_t q[$];
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    // Held-result model state for the registered instances.
    logic [15:0] m_s16;
    logic        m_c16;
    logic [7:0]  m_s8;
    logic        m_c8;
    logic        m_s1;
    logic        m_c1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t, input bit use_tbl);
        exp_t        e;
        exp_t        g;
        logic [16:0] r16;
        logic [8:0]  r8;
        logic [1:0]  r1;
        @(negedge clk);
        a_i = t.a;
        b_i = t.b;
        c_i = t.c;
        v_i = t.v;
        rst = t.r;

        if (t.r) begin
            e = '{v: 1'b0, s16: 16'h0, c16: 1'b0, s8: 8'h0, c8: 1'b0, s1: 1'b0, c1: 1'b0};
        end else if (t.v) begin
            r16 = {1'b0, t.a} + {1'b0, t.b} + {16'h0, t.c};
            r8  = {1'b0, t.a[7:0]} + {1'b0, t.b[7:0]} + {8'h0, t.c};
            r1  = {1'b0, t.a[0]} + {1'b0, t.b[0]} + {1'b0, t.c};
            e = '{v: 1'b1, s16: r16[15:0], c16: r16[16], s8: r8[7:0], c8: r8[8],
                  s1: r1[0], c1: r1[1]};
        end else begin
            e = '{v: 1'b0, s16: m_s16, c16: m_c16, s8: m_s8, c8: m_c8, s1: m_s1, c1: m_c1};
        end
        if (use_tbl) begin
            e.s8 = t.s8;
            e.c8 = t.c8;
            e.s1 = t.s1;
            e.c1 = t.c1;
        end
        m_s16 = e.s16; m_c16 = e.c16;
        m_s8  = e.s8;  m_c8  = e.c8;
        m_s1  = e.s1;  m_c1  = e.c1;
        q.push_back(e);

        // Combinational instance settles without any clock edge.
        #1;
        chk("comb_valid", {31'h0, vc}, {31'h0, t.v & ~t.r});
        if (!$isunknown({t.a[0], t.b[0], t.c})) begin
            chk("comb_sum",   {31'h0, sc[0]}, {31'h0, t.a[0] ^ t.b[0] ^ t.c});
            chk("comb_carry", {31'h0, cc},
                {31'h0, (t.a[0] & t.b[0]) | (t.c & (t.a[0] ^ t.b[0]))});
        end

        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            g = q.pop_front();
            chk("valid16", {31'h0, v16}, {31'h0, g.v});
            chk("valid8",  {31'h0, v8},  {31'h0, g.v});
            chk("valid1",  {31'h0, v1},  {31'h0, g.v});
            chk("sum16",   {16'h0, s16}, {16'h0, g.s16});
            chk("carry16", {31'h0, c16}, {31'h0, g.c16});
            chk("sum8",    {24'h0, s8},  {24'h0, g.s8});
            chk("carry8",  {31'h0, c8},  {31'h0, g.c8});
            chk("sum1",    {31'h0, s1[0]}, {31'h0, g.s1});
            chk("carry1",  {31'h0, c1},  {31'h0, g.c1});
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic c,
                                input logic v, input logic r, input logic [7:0] s8,
                                input logic c8, input logic s1, input logic c1);
        vec_t t;
        t = '{a: a, b: b, c: c, v: v, r: r, s8: s8, c8: c8, s1: s1, c1: c1};
        return t;
    endfunction

    initial begin
        logic [7:0] tt_s;
        logic [7:0] tt_c;
        logic [7:0] tt_s8 [8];
        vec_t       t;

        // Single-bit truth table indexed by {a,b,c}.
        tt_s  = 8'b1001_0110;
        tt_c  = 8'b1110_1000;
        tt_s8 = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd1, 8'd2, 8'd2, 8'd3};

        a_i = '0; b_i = '0; c_i = 1'b0; v_i = 1'b0; rst = 1'b1;

        // Reset held two cycles against an active input, then released.
        tbl.push_back(mk(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1));
        // Exhaustive single-bit truth table.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk({15'h0, i[2]}, {15'h0, i[1]}, i[0], 1'b1, 1'b0,
                             tt_s8[i], 1'b0, tt_s[i], tt_c[i]));
        end
        // 8-bit carry-out boundaries.
        tbl.push_back(mk(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(16'h007F, 16'h0080, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
        // Maximum operands.
        tbl.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1));
        // Hold behaviour while idle, including unknown inputs.
        tbl.push_back(mk(16'h0012, 16'h0034, 1'b0, 1'b1, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(16'h00FF, 16'h0034, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk('x,       'x,       1'bx, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0));
        // Mid-stream reset discards the operation sampled with it.
        tbl.push_back(mk(16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(16'h000F, 16'h0001, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1));

        foreach (tbl[i]) apply(tbl[i], 1'b1);

        // Combinational instance reacts between clock edges with no edge needed.
        @(negedge clk);
        a_i = 16'h0001; b_i = 16'h0001; c_i = 1'b0; v_i = 1'b1; rst = 1'b0;
        #1;
        chk("comb_nclk_sum",   {31'h0, sc[0]}, 32'h0);
        chk("comb_nclk_carry", {31'h0, cc},    32'h1);
        rst = 1'b1;
        #1;
        chk("comb_rst_valid",  {31'h0, vc},    32'h0);
        chk("comb_rst_carry",  {31'h0, cc},    32'h1);
        rst = 1'b0;
        @(posedge clk);
        // The registered instances sampled a valid 1+1+0 at that edge.
        #1;
        chk("hand_sum8",   {24'h0, s8}, 32'h2);
        chk("hand_carry1", {31'h0, c1}, 32'h1);
        m_s16 = 16'h0002; m_c16 = 1'b0;
        m_s8  = 8'h02;    m_c8  = 1'b0;
        m_s1  = 1'b0;     m_c1  = 1'b1;

        // Random vectors against the reference model.
        for (int i = 0; i < 1000; i++) begin
            t.a  = 16'($urandom);
            t.b  = 16'($urandom);
            t.c  = 1'($urandom);
            t.v  = ($urandom_range(0, 3) != 0);
            t.r  = ($urandom_range(0, 49) == 0);
            t.s8 = 8'h0; t.c8 = 1'b0; t.s1 = 1'b0; t.c1 = 1'b0;
            apply(t, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
